norm_lzc_pipe: RTL

NORM_LZC_PIPE -- requirements
Module: norm_lzc_pipe

---
 rtl/norm_lzc_pipe.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/norm_lzc_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : norm_lzc_pipe
// Description : Two-stage significand normalizer. Stage 1 captures the
//               operand together with its leading-zero count; stage 2 left
//               shifts the significand, clamping the shift to the exponent
//               so the result never underflows below exponent 0.
// Revision    : 1.0 - initial release
// ============================================================================
module norm_lzc_pipe #(
  parameter int WIDTH = 24,
  parameter int EW    = 8,
  parameter int LZW   = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_sig,
  input  logic [EW-1:0]    in_exp,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sig,
  output logic [EW-1:0]    out_exp,
  output logic [LZW-1:0]   out_lz,
  output logic             out_zero,
  output logic             out_uf
);

  // Common width for comparing the count against the exponent.
  localparam int c_cw = (LZW > EW) ? LZW : EW;

  logic             r_s1_valid;
  logic [WIDTH-1:0] r_s1_sig;
  logic [EW-1:0]    r_s1_exp;
  logic [LZW-1:0]   r_s1_lz;

  logic             r_s2_valid;
  logic [WIDTH-1:0] r_s2_sig;
  logic [EW-1:0]    r_s2_exp;
  logic [LZW-1:0]   r_s2_lz;
  logic             r_s2_zero;
  logic             r_s2_uf;

  logic             w_s1_move;
  logic [LZW-1:0]   w_lz;
  logic [c_cw-1:0]  w_lz_ext;
  logic [c_cw-1:0]  w_exp_ext;
  logic [c_cw-1:0]  w_shift;
  logic [WIDTH-1:0] w_n_sig;
  logic [EW-1:0]    w_n_exp;
  logic [LZW-1:0]   w_n_lz;
  logic             w_n_zero;
  logic             w_n_uf;

  // Stage 2 can take a new entry when it is empty or its result is leaving.
  assign w_s1_move = !r_s2_valid || out_ready;
  assign in_ready  = !r_s1_valid || w_s1_move;

  assign out_valid = r_s2_valid;
  assign out_sig   = r_s2_sig;
  assign out_exp   = r_s2_exp;
  assign out_lz    = r_s2_lz;
  assign out_zero  = r_s2_zero;
  assign out_uf    = r_s2_uf;

  // Leading-zero count: the highest set bit wins, all-zero gives WIDTH.
  always_comb begin
    w_lz = LZW'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (in_sig[i]) w_lz = LZW'(WIDTH - 1 - i);
    end
  end

  // Shift amount is the count, clamped to the exponent (denormal result).
  always_comb begin
    w_lz_ext  = c_cw'(r_s1_lz);
    w_exp_ext = c_cw'(r_s1_exp);
    w_shift   = '0;
    w_n_sig   = '0;
    w_n_exp   = '0;
    w_n_lz    = '0;
    w_n_zero  = 1'b0;
    w_n_uf    = 1'b0;
    if (r_s1_sig == '0) begin
      w_n_zero = 1'b1;
      w_n_lz   = LZW'(WIDTH);
    end else if (w_lz_ext <= w_exp_ext) begin
      w_shift = w_lz_ext;
      w_n_sig = r_s1_sig << w_shift;
      w_n_exp = EW'(w_exp_ext - w_lz_ext);
      w_n_lz  = LZW'(w_shift);
    end else begin
      w_shift = w_exp_ext;
      w_n_sig = r_s1_sig << w_shift;
      w_n_lz  = LZW'(w_shift);
      w_n_uf  = 1'b1;
    end
  end

  // Stage 1: capture operand and its leading-zero count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_sig   <= '0;
      r_s1_exp   <= '0;
      r_s1_lz    <= '0;
    end else if (in_ready) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_sig <= in_sig;
        r_s1_exp <= in_exp;
        r_s1_lz  <= w_lz;
      end
    end
  end

  // Stage 2: register the normalized result; frozen while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_s2_sig   <= '0;
      r_s2_exp   <= '0;
      r_s2_lz    <= '0;
      r_s2_zero  <= 1'b0;
      r_s2_uf    <= 1'b0;
    end else if (w_s1_move) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_sig  <= w_n_sig;
        r_s2_exp  <= w_n_exp;
        r_s2_lz   <= w_n_lz;
        r_s2_zero <= w_n_zero;
        r_s2_uf   <= w_n_uf;
      end
    end
  end

endmodule
`default_nettype wire
